keypad_debounce_decoder: RTL and testbench

- Sits directly downstream of the keypad column scanner FSM.
- Samples the 4 keypad row lines against the scanner's one-hot column drive, then debounces press and release.
- Emits a one-cycle strobe with the decoded 4-bit hex key.
- Returns button_pressed to the scanner so the scanner holds the active column while a key is down.

---
 rtl/keypad_debounce_decoder.sv | 177 +++++++++++++++++
 tb/tb_keypad_debounce_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce_decoder.sv
// Keypad row sampler: synchronises the row lines, debounces press and release
// against the scanner's column drive, and strobes the decoded hex key.
module keypad_debounce_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_raw,
    input  logic [3:0] col_keys,
    output logic       button_pressed,
    output logic [3:0] key_code,
    output logic       key_valid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Keypad legend indexed by {row, column}.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0:    k = 4'h1;
            4'h1:    k = 4'h2;
            4'h2:    k = 4'h3;
            4'h3:    k = 4'hA;
            4'h4:    k = 4'h4;
            4'h5:    k = 4'h5;
            4'h6:    k = 4'h6;
            4'h7:    k = 4'hB;
            4'h8:    k = 4'h7;
            4'h9:    k = 4'h8;
            4'hA:    k = 4'h9;
            4'hB:    k = 4'hC;
            4'hC:    k = 4'hE;
            4'hD:    k = 4'h0;
            4'hE:    k = 4'hF;
            4'hF:    k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    logic [3:0]       sync1_r;
    logic [3:0]       rows_s;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [3:0]       row_r;
    logic [3:0]       row_s;
    logic [3:0]       col_r;
    logic [3:0]       col_s;
    logic             load_s;
    logic             button_pressed_r;
    logic [3:0]       key_code_r;
    logic             key_valid_r;

    // Two-flop synchroniser for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 4'd0;
            rows_s  <= 4'd0;
        end else begin
            sync1_r <= rows_raw;
            rows_s  <= sync1_r;
        end
    end

    // Next-state, counter and capture logic for the debounce FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        row_s   = row_r;
        col_s   = col_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_onehot4(rows_s) && is_onehot4(col_keys)) begin
                    state_s = DEBOUNCE;
                    row_s   = rows_s;
                    col_s   = col_keys;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            DEBOUNCE: begin
                // A moving column counts as a bounce: the scanner gave up on this key.
                if ((rows_s != row_r) || (col_keys != col_r)) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_MAX) begin
                    state_s = HELD;
                    load_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                if ((rows_s & row_r) == 4'd0) begin
                    state_s = RELEASE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = HELD;
                end
            end
            RELEASE: begin
                if ((rows_s & row_r) != 4'd0) begin
                    state_s = HELD;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_MAX) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state, captured key and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r          <= IDLE;
            cnt_r            <= CNT_ZERO;
            row_r            <= 4'd0;
            col_r            <= 4'd0;
            button_pressed_r <= 1'b0;
            key_code_r       <= 4'h0;
            key_valid_r      <= 1'b0;
        end else begin
            state_r          <= state_s;
            cnt_r            <= cnt_s;
            row_r            <= row_s;
            col_r            <= col_s;
            button_pressed_r <= (state_s != IDLE);
            key_valid_r      <= load_s;
            if (load_s) begin
                key_code_r <= key_map(onehot_index(row_r), onehot_index(col_r));
            end else begin
                key_code_r <= key_code_r;
            end
        end
    end

    assign button_pressed = button_pressed_r;
    assign key_code       = key_code_r;
    assign key_valid      = key_valid_r;

endmodule

// File: tb/tb_keypad_debounce_decoder.sv
// Self-checking bench: a run-length model of the keypad rules is compared with
// the DUT every cycle, plus directed scenario checks with literal expectations.
module tb_keypad_debounce_decoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows_raw = 4'd0;
    logic [3:0] col_keys = 4'd0;
    logic       button_pressed;
    logic [3:0] key_code;
    logic       key_valid;

    keypad_debounce_decoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .rows_raw       (rows_raw),
        .col_keys       (col_keys),
        .button_pressed (button_pressed),
        .key_code       (key_code),
        .key_valid      (key_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int n_strobe = 0;
    int last_strobe = -1;
    int cyc = 0;

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int lim);
        n_checks++;
        if (act < lim) begin
            n_fail++;
            $display("FAIL %s: got %0d expected >= %0d (cycle %0d)", name, act, lim, cyc);
        end
    endtask

    function automatic int bitpos(input logic [3:0] v);
        int p = 0;
        for (int i = 0; i < 4; i++) if (v[i]) p = i;
        return p;
    endfunction

    // Model: a key is accepted after D+1 consecutive matching samples of a
    // single-row/single-column pattern, and released after D+1 consecutive
    // samples with its row absent.
    localparam int P_IDLE = 0, P_PRESS = 1, P_HELD = 2, P_REL = 3;
    int         m_phase = P_IDLE;
    int         m_run = 0;
    logic [3:0] h1 = 4'd0, h2 = 4'd0, rs;
    logic [3:0] m_row = 4'd0, m_col = 4'd0;
    logic [3:0] e_code = 4'h0;
    logic       e_valid = 1'b0, e_bp = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            h1 = 4'd0; h2 = 4'd0; m_phase = P_IDLE; m_run = 0;
            m_row = 4'd0; m_col = 4'd0; e_code = 4'h0; e_valid = 1'b0;
        end else begin
            rs = h2;
            h2 = h1;
            h1 = rows_raw;
            e_valid = 1'b0;
            if (m_phase == P_IDLE) begin
                if ($countones(rs) == 1 && $countones(col_keys) == 1) begin
                    m_phase = P_PRESS; m_row = rs; m_col = col_keys; m_run = 1;
                end
            end else if (m_phase == P_PRESS) begin
                if (rs != m_row || col_keys != m_col) m_phase = P_IDLE;
                else begin
                    m_run++;
                    if (m_run == D + 1) begin
                        m_phase = P_HELD;
                        e_code = kmap[bitpos(m_row) * 4 + bitpos(m_col)];
                        e_valid = 1'b1;
                    end
                end
            end else if (m_phase == P_HELD) begin
                if ((rs & m_row) == 4'd0) begin m_phase = P_REL; m_run = 1; end
            end else begin
                if ((rs & m_row) != 4'd0) m_phase = P_HELD;
                else begin
                    m_run++;
                    if (m_run == D + 1) m_phase = P_IDLE;
                end
            end
        end
        e_bp = (m_phase != P_IDLE);
    end

    // Per-cycle comparison against the model, plus strobe counting and spacing.
    always @(negedge clk) begin
        cyc++;
        chk("button_pressed", button_pressed, e_bp);
        chk("key_code", key_code, e_code);
        chk("key_valid", key_valid, e_valid);
        if (!reset) last_strobe = -1;
        if (key_valid === 1'b1) begin
            n_strobe++;
            if (last_strobe >= 0) chk_ge("strobe_spacing", cyc - last_strobe, 2 * D + 2);
            last_strobe = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int base;
    int k;

    initial begin
        // 1: reset with a key held, then a single fresh strobe
        rows_raw = 4'b0010; col_keys = 4'b0001;
        step(3);
        chk("t1_rst_bp", button_pressed, 1'b0);
        chk("t1_rst_code", key_code, 4'h0);
        chk("t1_rst_valid", key_valid, 1'b0);
        reset = 1'b1;
        base = n_strobe;
        step(30);
        chk("t1_strobes", n_strobe - base, 1);
        chk("t1_code", key_code, 4'h4);
        rows_raw = 4'd0;
        step(12);

        // 2: clean press r1/c2, release timing
        col_keys = 4'b0100; rows_raw = 4'b0010;
        base = n_strobe;
        step(20);
        rows_raw = 4'd0;
        k = 0;
        while (button_pressed === 1'b1 && k < 40) begin
            step(1);
            k++;
        end
        chk("t2_bp_fall", k, D + 3);
        chk("t2_strobes", n_strobe - base, 1);
        chk("t2_code", key_code, 4'h6);
        step(5);

        // 3: bouncing press rejected
        col_keys = 4'b0001;
        base = n_strobe;
        for (int i = 0; i < 3; i++) begin
            rows_raw = 4'b1000; step(2);
            rows_raw = 4'b0000; step(2);
        end
        step(10);
        chk("t3_strobes", n_strobe - base, 0);
        chk("t3_code", key_code, 4'h6);
        chk("t3_bp", button_pressed, 1'b0);

        // 4: release bounce on r3/c1
        col_keys = 4'b0010; rows_raw = 4'b1000;
        base = n_strobe;
        step(12);
        chk("t4_code", key_code, 4'h0);
        rows_raw = 4'd0;    step(2);
        rows_raw = 4'b1000; step(1);
        rows_raw = 4'd0;    step(15);
        chk("t4_strobes", n_strobe - base, 1);
        chk("t4_bp", button_pressed, 1'b0);

        // 5: multi-key in IDLE, then second key during HELD
        col_keys = 4'b0001; rows_raw = 4'b0011;
        base = n_strobe;
        step(10);
        chk("t5_multi_strobes", n_strobe - base, 0);
        chk("t5_multi_bp", button_pressed, 1'b0);
        rows_raw = 4'b0001; step(12);
        chk("t5_code", key_code, 4'h1);
        rows_raw = 4'b0101; step(10);
        chk("t5_held_bp", button_pressed, 1'b1);
        rows_raw = 4'd0;    step(12);
        chk("t5_strobes", n_strobe - base, 1);

        // Reset during HELD, then fresh detection
        col_keys = 4'b1000; rows_raw = 4'b0100;
        step(15);
        chk("tr_code_pre", key_code, 4'hC);
        reset = 1'b0; step(1);
        chk("tr_bp", button_pressed, 1'b0);
        chk("tr_code", key_code, 4'h0);
        chk("tr_valid", key_valid, 1'b0);
        reset = 1'b1;
        base = n_strobe;
        step(20);
        chk("tr_strobes", n_strobe - base, 1);
        chk("tr_code_post", key_code, 4'hC);
        rows_raw = 4'd0; step(12);

        // 6: full key map sweep
        base = n_strobe;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                rows_raw = 4'(1 << r); col_keys = 4'(1 << c);
                step(12);
                chk("t6_code", key_code, kmap[r * 4 + c]);
                rows_raw = 4'd0;
                step(10);
            end
        end
        chk("t6_strobes", n_strobe - base, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
